stage_if_fetch: RTL and testbench
=================================

Name: stage_if_fetch

Overview:
Instruction-fetch stage of the RV32I pipeline.
- Owns the fetch PC and issues one instruction-memory request at a time.
- Handles stall back-pressure and branch/jump redirects.
- Presents registered pc / inst_IFID / if_valid to the IF/ID pipeline register directly downstream.
- Inserts a NOP bubble whenever no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INST, 32'h0000_0013, instruction injected on bubbles/flushes (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
nrst  in  1  asynchronous reset, active-high (1 = reset)
stall  in  1  hazard unit: hold IF outputs and fetch PC this cycle
redirect  in  1  taken branch/jump from EX: flush and refetch
redirect_pc  in  32  new fetch address, valid with redirect
imem_req  out  1  memory request, level-held until imem_ack
imem_addr  out  32  word address of request, stable while imem_req=1 and no ack
imem_ack  in  1  read data valid; only asserted while imem_req=1; may occur in the request's first cycle
imem_rdata  in  32  instruction word, valid with imem_ack
pc  out  32  PC of presented instruction, to IF/ID pc input
inst_IFID  out  32  presented instruction, to IF/ID inst_IFID input
if_valid  out  1  1 = inst_IFID is a real instruction, 0 = bubble

Behaviour:
Reset (nrst=1, asynchronous):
- fetch_pc=RESET_PC, state=FETCH, imem_req=0.
- pc=RESET_PC, inst_IFID=NOP_INST, if_valid=0, hold buffer cleared.
- First cycle after release: imem_req=1, imem_addr=RESET_PC.

State FETCH: imem_req=1, imem_addr=fetch_pc.
- ack & !stall & !redirect: pc<=fetch_pc, inst_IFID<=imem_rdata, if_valid<=1, fetch_pc<=fetch_pc+4. Stay FETCH; a zero-wait memory gives one instruction per cycle.
- ack & stall & !redirect: hold_inst<=imem_rdata, hold_pc<=fetch_pc, go HOLD. Outputs unchanged.
- !ack & !stall: inst_IFID<=NOP_INST, if_valid<=0, pc unchanged. Stay FETCH.
- !ack & stall: all outputs hold.

State HOLD: imem_req=0, outputs hold while stall=1.
- stall falls: pc<=hold_pc, inst_IFID<=hold_inst, if_valid<=1, fetch_pc<=hold_pc+4, go FETCH.

State KILL: imem_req=1, imem_addr=kill_addr, where kill_addr is the address of the abandoned request.
- Response is discarded. On ack go FETCH (new fetch_pc already loaded).
- While in KILL with stall=0: inst_IFID=NOP_INST, if_valid=0.

Redirect (highest priority, overrides stall, any state):
- fetch_pc<=redirect_pc with bits[1:0] forced to 0.
- inst_IFID<=NOP_INST, if_valid<=0, pc unchanged, hold buffer discarded.
- In FETCH without ack: kill_addr<=fetch_pc, go KILL, so the handshake address stays stable.
- In FETCH with ack, or in HOLD: go FETCH directly.
- In KILL: stay KILL; an ack in the same cycle returns to FETCH.

Arithmetic and timing:
- fetch_pc+4 is modulo 2^32: 0xFFFF_FFFC wraps to 0x0000_0000.
- Exactly one outstanding request at any time.
- Latency from imem_ack to outputs is 1 cycle (registered).

Test Plan:
- Reset/stream: release reset with ack tied high → imem_addr 0,4,8…; outputs pc=0/inst=rdata@0 one cycle after each ack, if_valid=1 every cycle; during reset pc=0, inst=0x13, if_valid=0.
- Wait states: ack every 3rd cycle, stall=0 → imem_addr stable while waiting; if_valid pulses 1 for one cycle per ack, inst=0x13 otherwise.
- Stall with data: stall=1 on the ack cycle for fetch_pc=0x10, held 4 cycles → imem_req=0 in HOLD; outputs frozen; after release, pc=0x10 with buffered inst, then next request addr=0x14.
- Redirect mid-wait: request at 0x20 pending, redirect=1 redirect_pc=0x103 → KILL keeps imem_addr=0x20 until ack, data dropped, if_valid=0; next request addr=0x100.
- Redirect+stall simultaneous in HOLD → hold buffer dropped, if_valid=0, inst=0x13; next request addr=redirect_pc.
- Wrap/async reset: RESET_PC=0xFFFF_FFFC → second request addr=0x0; assert nrst mid-request → imem_req drops same cycle without waiting for clk.

Source files
------------

// File: rtl/stage_if_fetch.sv
// RV32I fetch stage: one outstanding imem request, stall hold buffer, redirect kill.
// Outputs are registered 1 cycle after imem_ack; stall freezes outputs; redirect overrides everything.
module stage_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst_IFID,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] kill_addr;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (redirect) begin
                    state_nxt = imem_ack ? FETCH : KILL;
                end else if (imem_ack && stall) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_nxt = FETCH;
                end
            end
            KILL: begin
                if (imem_ack) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Gating with nrst drops the request the moment reset is asserted, not at the next edge.
    always_comb begin
        imem_req  = !nrst && (state != HOLD);
        imem_addr = (state == KILL) ? kill_addr : fetch_pc;
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            fetch_pc  <= RESET_PC;
            kill_addr <= RESET_PC;
            hold_pc   <= 32'd0;
            hold_inst <= 32'd0;
            pc        <= RESET_PC;
            inst_IFID <= NOP_INST;
            if_valid  <= 1'b0;
        end else if (redirect) begin
            fetch_pc  <= {redirect_pc[31:2], 2'b00};
            inst_IFID <= NOP_INST;
            if_valid  <= 1'b0;
            hold_pc   <= 32'd0;
            hold_inst <= 32'd0;
            // An unanswered request must keep its address on the bus until acked.
            if (state == FETCH && !imem_ack) begin
                kill_addr <= fetch_pc;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        if (stall) begin
                            hold_inst <= imem_rdata;
                            hold_pc   <= fetch_pc;
                        end else begin
                            pc        <= fetch_pc;
                            inst_IFID <= imem_rdata;
                            if_valid  <= 1'b1;
                            fetch_pc  <= fetch_pc + 32'd4;
                        end
                    end else if (!stall) begin
                        inst_IFID <= NOP_INST;
                        if_valid  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc        <= hold_pc;
                        inst_IFID <= hold_inst;
                        if_valid  <= 1'b1;
                        fetch_pc  <= hold_pc + 32'd4;
                    end
                end
                KILL: begin
                    if (!stall) begin
                        inst_IFID <= NOP_INST;
                        if_valid  <= 1'b0;
                    end
                end
                default: begin
                    inst_IFID <= NOP_INST;
                    if_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_if_fetch.sv
// Bench for stage_if_fetch: directed scenarios plus random traffic against a request-level model.
module tb_stage_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] inst_IFID;
    logic        if_valid;

    logic        nrst2 = 1'b0;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] rdata2;
    logic        ack2;
    logic [31:0] pc2;
    logic [31:0] inst2;
    logic        valid2;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
    endfunction

    assign ack2   = req2;
    assign rdata2 = memf(addr2);

    stage_if_fetch u_dut (
        .clk(clk), .nrst(nrst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc),
        .inst_IFID(inst_IFID), .if_valid(if_valid)
    );

    stage_if_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .nrst(nrst2), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'd0), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2), .pc(pc2),
        .inst_IFID(inst2), .if_valid(valid2)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference model: tracks the outstanding request, whether its data is doomed, and parked data.
    logic [31:0] m_fetch_pc;
    logic [31:0] m_kill_addr;
    bit          m_discard;
    logic [63:0] held_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_valid;

    task automatic model_reset();
        m_fetch_pc  = 32'd0;
        m_kill_addr = 32'd0;
        m_discard   = 1'b0;
        held_q.delete();
        m_pc        = 32'd0;
        m_inst      = NOP;
        m_valid     = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc,
                              input bit a, input logic [31:0] rdat);
        logic [63:0] h;
        if (rd) begin
            m_inst  = NOP;
            m_valid = 1'b0;
            if (a) begin
                m_discard = 1'b0;
            end else if (held_q.size() == 0) begin
                if (!m_discard) m_kill_addr = m_fetch_pc;
                m_discard = 1'b1;
            end
            held_q.delete();
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
        end else if (held_q.size() != 0) begin
            if (!st) begin
                h          = held_q.pop_front();
                m_pc       = h[63:32];
                m_inst     = h[31:0];
                m_valid    = 1'b1;
                m_fetch_pc = h[63:32] + 32'd4;
            end
        end else if (m_discard) begin
            if (!st) begin
                m_inst  = NOP;
                m_valid = 1'b0;
            end
            if (a) m_discard = 1'b0;
        end else if (a) begin
            if (st) begin
                held_q.push_back({m_fetch_pc, rdat});
            end else begin
                m_pc       = m_fetch_pc;
                m_inst     = rdat;
                m_valid    = 1'b1;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end else if (!st) begin
            m_inst  = NOP;
            m_valid = 1'b0;
        end
    endtask

    // One clock: check bus, drive inputs, clock, advance model, check registered outputs.
    task automatic cyc(input bit st, input bit rd, input logic [31:0] rpc, input bit want_ack);
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          a;
        exp_req  = (held_q.size() == 0);
        exp_addr = m_discard ? m_kill_addr : m_fetch_pc;
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, exp_addr);
        a           = want_ack && exp_req;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = a;
        imem_rdata  = a ? memf(exp_addr) : $urandom;
        @(posedge clk);
        model_step(st, rd, rpc, a, imem_rdata);
        #1;
        chk("pc", pc, m_pc);
        chk("inst_IFID", inst_IFID, m_inst);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    endtask

    initial begin
        nrst  = 1'b1;
        nrst2 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_inst", inst_IFID, NOP);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        nrst = 1'b0;
        model_reset();
        #1;

        // Zero-wait stream up to fetch_pc = 0x10.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        // Stall on the ack cycle, held four cycles, then release.
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("hold_req_low", {31'd0, imem_req}, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        chk("hold_release_pc", pc, 32'h10);
        chk("after_hold_addr", imem_addr, 32'h14);
        // Wait states: ack every third cycle.
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 32'd0, (i % 3) == 2);
        // Redirect while the request at 0x20 is pending.
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'h103, 1'b0);
        chk("kill_addr", imem_addr, 32'h20);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("kill_dropped", {31'd0, if_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        // Redirect and stall together while holding data.
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b1, 32'h200, 1'b0);
        chk("hold_redir_inst", inst_IFID, NOP);
        chk("hold_redir_addr", imem_addr, 32'h200);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0, $urandom,
                $urandom_range(1, 0) == 1);
        end

        // Asynchronous reset in the middle of a request.
        cyc(1'b0, 1'b1, 32'h40, 1'b0);
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        nrst = 1'b1;
        #1;
        chk("async_req_drop", {31'd0, imem_req}, 32'd0);
        chk("async_pc", pc, 32'd0);
        chk("async_valid", {31'd0, if_valid}, 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1);

        // Wrap-around from RESET_PC = 0xFFFF_FFFC.
        @(posedge clk);
        #1;
        nrst2 = 1'b0;
        #1;
        chk("wrap_req", {31'd0, req2}, 32'd1);
        chk("wrap_addr0", addr2, WRAP_PC);
        @(posedge clk);
        #1;
        chk("wrap_addr1", addr2, 32'd0);
        chk("wrap_pc0", pc2, WRAP_PC);
        chk("wrap_inst0", inst2, memf(WRAP_PC));
        chk("wrap_valid0", {31'd0, valid2}, 32'd1);
        @(posedge clk);
        #1;
        chk("wrap_addr2", addr2, 32'd4);
        chk("wrap_pc1", pc2, 32'd0);
        #2;
        nrst2 = 1'b1;
        #1;
        chk("wrap_async_req", {31'd0, req2}, 32'd0);
        chk("wrap_async_pc", pc2, WRAP_PC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
